// File: rtl/irqc_pkg.sv
// irqc_pkg: register offsets and constants shared by the interrupt controller.
package irqc_pkg;
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_MASK   = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_VECTOR = 3'd3;
    localparam logic [2:0] REG_FORCE  = 3'd4;
    localparam logic [7:0] VEC_NONE   = 8'h80;
    localparam int         NMI_PULSE  = 2;
endpackage

// File: rtl/irqc_sync.sv
// irqc_sync: two-flop synchronizer plus previous-value flop for one interrupt source.
module irqc_sync (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic level,
    output logic rise
);
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= a;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    assign level = s2_q;
    assign rise  = s2_q & ~prev_q;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller driving the cpu6502 irq_n/nmi_n inputs.
// Define IRQC_NMI_EN to make source NUM_SRC-1 a pulsed nmi_n source.
module irq_ctrl
    import irqc_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hD000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr,
    input  logic [7:0]         wdata,
    input  logic               rw,
    input  logic               bus_en,
    output logic [7:0]         rdata,
    output logic               hit,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq_n,
    output logic               nmi_n
);
    localparam logic [7:0] VALID = 8'((9'd1 << NUM_SRC) - 9'd1);
`ifdef IRQC_NMI_EN
    localparam logic [7:0] NMI_BIT = 8'(9'd1 << (NUM_SRC - 1));
`else
    localparam logic [7:0] NMI_BIT = 8'h00;
`endif
    localparam logic [7:0] IRQ_SEL = VALID & ~NMI_BIT;

    logic [7:0] lvl, rise, set, clr, act, vec;
    logic [7:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d;
    logic       irq_n_q, irq_n_d, wr;
    logic [2:0] off;

    assign off = addr[2:0];
    assign hit = addr[15:3] == BASE_ADDR[15:3];
    assign wr  = bus_en & ~rw & hit;

    for (genvar g = 0; g < 8; g++) begin : g_src
        if (g < NUM_SRC) begin : g_on
            irqc_sync u_sync (
                .clk   (clk),
                .reset (reset),
                .a     (src[g]),
                .level (lvl[g]),
                .rise  (rise[g])
            );
        end else begin : g_off
            assign lvl[g]  = 1'b0;
            assign rise[g] = 1'b0;
        end
    end

    // Edge-mode bits: set beats W1C. Level-mode bits just track the synchronized input.
    always_comb begin
        set     = rise | ((wr && off == REG_FORCE) ? wdata : 8'h00);
        clr     = (wr && off == REG_STATUS) ? wdata : 8'h00;
        pend_d  = VALID & ((mode_q & (set | (pend_q & ~clr))) | (~mode_q & lvl));
        mask_d  = (wr && off == REG_MASK) ? wdata & VALID : mask_q;
        mode_d  = (wr && off == REG_MODE) ? wdata & VALID : mode_q;
        act     = pend_q & mask_q & IRQ_SEL;
        irq_n_d = ~|act;
        vec     = VEC_NONE;
        for (int i = 7; i >= 0; i--)
            if (act[i]) vec = 8'(i);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pend_q  <= 8'h00;
            mask_q  <= 8'h00;
            mode_q  <= 8'h00;
            irq_n_q <= 1'b1;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            irq_n_q <= irq_n_d;
        end

    always_comb
        rdata = !hit                ? 8'h00  :
                off == REG_STATUS   ? pend_q :
                off == REG_MASK     ? mask_q :
                off == REG_MODE     ? mode_q :
                off == REG_VECTOR   ? vec    : 8'h00;

    assign irq_n = irq_n_q;

`ifdef IRQC_NMI_EN
    localparam int CW = $clog2(NMI_PULSE + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nmi_n_q, nmi_n_d;
    // A fresh edge reloads the count, so back-to-back edges stretch the pulse.
    always_comb begin
        cnt_d   = rise[NUM_SRC-1] ? CW'(NMI_PULSE) : cnt_q - CW'(cnt_q != '0);
        nmi_n_d = cnt_d == '0;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt_q   <= '0;
            nmi_n_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            nmi_n_q <= nmi_n_d;
        end
    assign nmi_n = nmi_n_q;
`else
    assign nmi_n = 1'b1;
`endif
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (honours IRQC_NMI_EN).
module tb_irq_ctrl;
    logic        clk = 1'b0, reset = 1'b1, rw = 1'b1, bus_en = 1'b0;
    logic        hit, irq_n, nmi_n;
    logic [15:0] addr = 16'hD000;
    logic [7:0]  wdata = 8'h00, rdata, src = 8'h00;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .rw     (rw),
        .bus_en (bus_en),
        .rdata  (rdata),
        .hit    (hit),
        .src    (src),
        .irq_n  (irq_n),
        .nmi_n  (nmi_n)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        @(negedge clk);
        addr   = 16'hD000 | 16'(off);
        wdata  = d;
        rw     = 1'b0;
        bus_en = 1'b1;
        @(negedge clk);
        bus_en = 1'b0;
        rw     = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
        addr = 16'hD000 | 16'(off);
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rst_exp [8];
        rst_exp = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) rd($sformatf("reset_off%0d", i), 3'(i), rst_exp[i]);
        check("reset_irq_n", 8'(irq_n), 8'h01);
        check("reset_nmi_n", 8'(nmi_n), 8'h01);
        addr = 16'hD008;
        #1 check("miss_hit", 8'(hit), 8'h00);
        check("miss_rdata", rdata, 8'h00);
        addr = 16'hD003;
        #1 check("hit", 8'(hit), 8'h01);

        // Edge source pulse: latency through synchronizer, pending and irq flop
        wr(REG_MODE_OFF(2), 8'h04);
        wr(3'd1, 8'h04);
        src[2] = 1'b1;
        @(negedge clk) src[2] = 1'b0;
        @(negedge clk) rd("edge_status_early", 3'd0, 8'h00);
        @(negedge clk) rd("edge_status", 3'd0, 8'h04);
        check("edge_irq_early", 8'(irq_n), 8'h01);
        @(negedge clk) check("edge_irq", 8'(irq_n), 8'h00);
        rd("edge_vector", 3'd3, 8'h02);
        wr(3'd0, 8'h04);
        check("w1c_irq_hold", 8'(irq_n), 8'h00);
        rd("w1c_vector", 3'd3, 8'h80);
        rd("w1c_status", 3'd0, 8'h00);
        @(negedge clk) check("w1c_irq_release", 8'(irq_n), 8'h01);

        // Level source: W1C ignored, follows the input
        wr(3'd2, 8'h00);
        wr(3'd1, 8'h03);
        src[1] = 1'b1;
        repeat (4) @(negedge clk);
        check("level_irq", 8'(irq_n), 8'h00);
        rd("level_status", 3'd0, 8'h02);
        wr(3'd0, 8'h02);
        rd("level_w1c", 3'd0, 8'h02);
        src[1] = 1'b0;
        repeat (3) @(negedge clk);
        rd("level_drop_status", 3'd0, 8'h00);
        check("level_drop_irq_hold", 8'(irq_n), 8'h00);
        @(negedge clk) check("level_drop_irq", 8'(irq_n), 8'h01);

        // FORCE, priority, set-beats-clear
        wr(3'd2, 8'hFF);
        wr(3'd1, 8'hFF);
        wr(3'd4, 8'h30);
        rd("force_status", 3'd0, 8'h30);
        rd("force_vector", 3'd3, 8'h04);
        rd("force_read", 3'd4, 8'h00);
        src[4] = 1'b1;
        @(negedge clk);
        wr(3'd0, 8'h10);
        rd("set_wins", 3'd0, 8'h30);
        wr(3'd0, 8'h20);
        rd("w1c_bit5", 3'd0, 8'h10);
        wr(3'd0, 8'h10);
        rd("held_high_no_edge", 3'd0, 8'h00);
        src[4] = 1'b0;

        // Mask gating and asynchronous reset mid-pending
        wr(3'd1, 8'h00);
        wr(3'd4, 8'h20);
        @(negedge clk) check("masked_irq", 8'(irq_n), 8'h01);
        rd("masked_vector", 3'd3, 8'h80);
        wr(3'd1, 8'h20);
        check("mask_irq_hold", 8'(irq_n), 8'h01);
        @(negedge clk) check("mask_irq", 8'(irq_n), 8'h00);
        reset = 1'b0;
        #1 check("midrst_irq", 8'(irq_n), 8'h01);
        check("midrst_nmi", 8'(nmi_n), 8'h01);
        rd("midrst_status", 3'd0, 8'h00);
        rd("midrst_mask", 3'd1, 8'h00);
        rd("midrst_mode", 3'd2, 8'h00);
        rd("midrst_vector", 3'd3, 8'h80);
        @(negedge clk) reset = 1'b1;

        // Top source: NMI when enabled, ordinary irq source otherwise
        wr(3'd2, 8'h80);
        wr(3'd1, 8'hFF);
        src[7] = 1'b1;
        @(negedge clk) check("top_nmi_n1", 8'(nmi_n), 8'h01);
        @(negedge clk) check("top_nmi_n2", 8'(nmi_n), 8'h01);
        @(negedge clk) rd("top_status", 3'd0, 8'h80);
`ifdef IRQC_NMI_EN
        check("nmi_low1", 8'(nmi_n), 8'h00);
        @(negedge clk) check("nmi_low2", 8'(nmi_n), 8'h00);
        check("nmi_irq", 8'(irq_n), 8'h01);
        @(negedge clk) check("nmi_end", 8'(nmi_n), 8'h01);
        check("nmi_irq_after", 8'(irq_n), 8'h01);
        rd("nmi_vector", 3'd3, 8'h80);
`else
        check("top_nmi_tied", 8'(nmi_n), 8'h01);
        @(negedge clk) check("top_irq", 8'(irq_n), 8'h00);
        rd("top_vector", 3'd3, 8'h07);
        check("top_nmi_after", 8'(nmi_n), 8'h01);
`endif
        src[7] = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [2:0] REG_MODE_OFF(input int o);
        return 3'(o);
    endfunction
endmodule
